// File: rtl/swd_seq_scheduler.sv
// rtl/swd_seq_scheduler.sv - SWD pin owner arbitrating raw sequences against frontend transfers
//
// Purpose:
//   Shares the SWD pins between raw sequences generated here (line reset, idle zeros,
//   JTAG-to-SWD switch) and frontend transfers. A raw sequence holds the frontend off the
//   bus through fe_hold and drives one SWDIO bit per cycle. A transfer grants the bus to the
//   frontend until it strobes xfer_done or the watchdog revokes the grant.
//
// Ports:
//   sck          - clock, all logic on posedge
//   rst          - synchronous active-high reset
//   seq_req      - raw sequence request (level, sampled in S_IDLE)
//   seq_op       - 0=LINE_RESET 1=IDLE 2=JTAG2SWD 3=reserved
//   seq_ack      - 1-cycle pulse, sequence accepted
//   seq_done     - 1-cycle pulse, sequence finished and bus released
//   seq_err      - 1-cycle pulse, reserved op rejected
//   xfer_req     - frontend transfer request (level, sampled in S_IDLE)
//   xfer_gnt     - frontend owns the bus while high
//   xfer_done    - frontend completion strobe, honoured only while granted
//   xfer_timeout - 1-cycle pulse, watchdog revoked the grant
//   fe_hold      - keeps the frontend off SWDIO during raw sequences
//   swclk_en     - SWCLK gate during raw sequences
//   swdio_oe     - raw-sequence SWDIO drive enable
//   swdio_out    - raw-sequence SWDIO value
//   busy         - high whenever not idle
module swd_seq_scheduler #(
    parameter int RESET_ONES   = 64,
    parameter int IDLE_ZEROS   = 50,
    parameter int TAIL_ZEROS   = 2,
    parameter int XFER_TIMEOUT = 1024
) (
    input  logic       sck,
    input  logic       rst,
    input  logic       seq_req,
    input  logic [1:0] seq_op,
    output logic       seq_ack,
    output logic       seq_done,
    output logic       seq_err,
    input  logic       xfer_req,
    output logic       xfer_gnt,
    input  logic       xfer_done,
    output logic       xfer_timeout,
    output logic       fe_hold,
    output logic       swclk_en,
    output logic       swdio_oe,
    output logic       swdio_out,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ONES1,
        S_SW16,
        S_ONES2,
        S_ZEROS,
        S_XFER,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_IDLE     = 2'd1;
    localparam logic [1:0] OP_JTAG2SWD = 2'd2;
    localparam logic [1:0] OP_RSVD     = 2'd3;

    localparam logic RR_SEQ  = 1'b0;
    localparam logic RR_XFER = 1'b1;

    localparam logic [7:0] RESET_LAST = 8'(RESET_ONES - 1);
    localparam logic [7:0] IDLE_LAST  = 8'(IDLE_ZEROS - 1);
    localparam logic [7:0] TAIL_LAST  = 8'(TAIL_ZEROS - 1);
    localparam logic [7:0] SW16_LAST  = 8'd15;

    // JTAG-to-SWD select code, shifted out LSB first.
    localparam logic [15:0] SW16_CODE = 16'hE79E;

    // A zero timeout disables the watchdog; keep the counter at least one bit wide.
    localparam int WD_W    = (XFER_TIMEOUT > 0) ? $clog2(XFER_TIMEOUT + 1) : 1;
    localparam int WD_LAST = (XFER_TIMEOUT > 0) ? XFER_TIMEOUT - 1 : 0;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [1:0]        op_q, op_d;
    logic              rr_last_q, rr_last_d;
    logic              seq_ack_q, seq_ack_d;
    logic              seq_err_q, seq_err_d;
    logic              xfer_timeout_q, xfer_timeout_d;
    logic              seq_win;
    logic              xfer_win;
    logic [3:0]        sw_idx;

    always_ff @(posedge sck) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            wd_q           <= '0;
            op_q           <= '0;
            rr_last_q      <= RR_XFER;
            seq_ack_q      <= 1'b0;
            seq_err_q      <= 1'b0;
            xfer_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wd_q           <= wd_d;
            op_q           <= op_d;
            rr_last_q      <= rr_last_d;
            seq_ack_q      <= seq_ack_d;
            seq_err_q      <= seq_err_d;
            xfer_timeout_q <= xfer_timeout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wd_d           = wd_q;
        op_d           = op_q;
        rr_last_d      = rr_last_q;
        seq_ack_d      = 1'b0;
        seq_err_d      = 1'b0;
        xfer_timeout_d = 1'b0;

        // On a tie the requester that did not win last time gets the bus.
        seq_win  = seq_req && (!xfer_req || (rr_last_q == RR_XFER));
        xfer_win = xfer_req && !seq_win;

        case (state_q)
            S_IDLE: begin
                if (seq_win) begin
                    seq_ack_d = 1'b1;
                    if (seq_op == OP_RSVD) begin
                        // Rejected op: no bus activity and the round-robin pointer stays put.
                        seq_err_d = 1'b1;
                    end else begin
                        op_d      = seq_op;
                        rr_last_d = RR_SEQ;
                        if (seq_op == OP_IDLE) begin
                            state_d = S_ZEROS;
                            cnt_d   = IDLE_LAST;
                        end else begin
                            state_d = S_ONES1;
                            cnt_d   = RESET_LAST;
                        end
                    end
                end else if (xfer_win) begin
                    state_d   = S_XFER;
                    wd_d      = '0;
                    rr_last_d = RR_XFER;
                end
            end
            S_ONES1: begin
                if (cnt_q == 8'd0) begin
                    if (op_q == OP_JTAG2SWD) begin
                        state_d = S_SW16;
                        cnt_d   = SW16_LAST;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_SW16: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_ONES2;
                    cnt_d   = RESET_LAST;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_ONES2: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_ZEROS;
                    cnt_d   = TAIL_LAST;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_ZEROS: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_XFER: begin
                // A completion in the final watchdog cycle wins over the timeout.
                if (xfer_done) begin
                    state_d = S_IDLE;
                end else if ((XFER_TIMEOUT != 0) && (wd_q == WD_W'(WD_LAST))) begin
                    state_d        = S_IDLE;
                    xfer_timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bit position within the select code: the counter runs 15 down to 0.
    assign sw_idx = 4'd15 - cnt_q[3:0];

    always_comb begin
        fe_hold   = 1'b0;
        swdio_out = 1'b0;
        case (state_q)
            S_ONES1, S_ONES2: begin
                fe_hold   = 1'b1;
                swdio_out = 1'b1;
            end
            S_SW16: begin
                fe_hold   = 1'b1;
                swdio_out = SW16_CODE[sw_idx];
            end
            S_ZEROS: begin
                fe_hold   = 1'b1;
            end
            default: begin
                fe_hold   = 1'b0;
                swdio_out = 1'b0;
            end
        endcase
    end

    assign swclk_en     = fe_hold;
    assign swdio_oe     = fe_hold;
    assign seq_done     = (state_q == S_DONE);
    assign xfer_gnt     = (state_q == S_XFER);
    assign busy         = (state_q != S_IDLE);
    assign seq_ack      = seq_ack_q;
    assign seq_err      = seq_err_q;
    assign xfer_timeout = xfer_timeout_q;

endmodule

// File: tb/tb_swd_seq_scheduler.sv
// tb/tb_swd_seq_scheduler.sv - self-checking bench for swd_seq_scheduler
module tb_swd_seq_scheduler;

    logic       sck = 1'b0;
    logic       rst;
    logic       seq_req;
    logic [1:0] seq_op;
    logic       seq_ack, seq_done, seq_err;
    logic       xfer_req, xfer_gnt, xfer_done, xfer_timeout;
    logic       fe_hold, swclk_en, swdio_oe, swdio_out, busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] op;
        int         len;
        logic       err;
    } vec_t;

    vec_t vecs[5];
    logic [0:15] sw_bits;

    swd_seq_scheduler #(
        .RESET_ONES  (64),
        .IDLE_ZEROS  (50),
        .TAIL_ZEROS  (2),
        .XFER_TIMEOUT(8)
    ) dut (
        .sck         (sck),
        .rst         (rst),
        .seq_req     (seq_req),
        .seq_op      (seq_op),
        .seq_ack     (seq_ack),
        .seq_done    (seq_done),
        .seq_err     (seq_err),
        .xfer_req    (xfer_req),
        .xfer_gnt    (xfer_gnt),
        .xfer_done   (xfer_done),
        .xfer_timeout(xfer_timeout),
        .fe_hold     (fe_hold),
        .swclk_en    (swclk_en),
        .swdio_oe    (swdio_oe),
        .swdio_out   (swdio_out),
        .busy        (busy)
    );

    always #5 sck = ~sck;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge sck);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {seq_ack, seq_done, seq_err, xfer_gnt, xfer_timeout,
                fe_hold, swclk_en, swdio_oe, swdio_out, busy};
    endfunction

    function automatic logic exp_bit(input logic [1:0] op, input int i);
        if (op == 2'd0) return 1'b1;
        if (op == 2'd1) return 1'b0;
        if (i < 64) return 1'b1;
        if (i < 80) return sw_bits[i-64];
        if (i < 144) return 1'b1;
        return 1'b0;
    endfunction

    // Pulses seq_req for one cycle and follows the sequence through to idle.
    task automatic run_seq(input logic [1:0] op, input int exp_len, input logic exp_err);
        int n;
        int bad;
        int acks;
        seq_req = 1'b1;
        seq_op  = op;
        tick;
        seq_req = 1'b0;
        seq_op  = 2'd0;
        chk($sformatf("ack_op%0d", op), seq_ack, 1);
        chk($sformatf("err_op%0d", op), seq_err, exp_err);
        n = 0;
        bad = 0;
        acks = 0;
        while (swdio_oe && n < 400) begin
            if (swdio_out !== exp_bit(op, n)) bad++;
            if (!fe_hold || !swclk_en) bad++;
            if (n > 0 && seq_ack) acks++;
            n++;
            tick;
        end
        chk($sformatf("len_op%0d", op), n, exp_len);
        chk($sformatf("bits_op%0d", op), bad, 0);
        chk($sformatf("extra_ack_op%0d", op), acks, 0);
        chk($sformatf("done_op%0d", op), seq_done, !exp_err);
        chk($sformatf("released_op%0d", op), {fe_hold, swclk_en, swdio_oe, swdio_out}, 0);
        tick;
        chk($sformatf("done_gone_op%0d", op), seq_done, 0);
        chk($sformatf("idle_op%0d", op), busy, 0);
    endtask

    task automatic wait_seq_done(input string name);
        int n;
        n = 0;
        while (!seq_done && n < 400) begin
            n++;
            tick;
        end
        chk(name, seq_done, 1);
        tick;
    endtask

    initial begin
        sw_bits = 16'b0111100111100111;
        vecs[0] = '{op: 2'd0, len: 64,  err: 1'b0};
        vecs[1] = '{op: 2'd1, len: 50,  err: 1'b0};
        vecs[2] = '{op: 2'd2, len: 146, err: 1'b0};
        vecs[3] = '{op: 2'd3, len: 0,   err: 1'b1};
        vecs[4] = '{op: 2'd0, len: 64,  err: 1'b0};

        rst = 1'b1;
        seq_req = 1'b0;
        seq_op = 2'd0;
        xfer_req = 1'b0;
        xfer_done = 1'b0;
        tick;
        tick;
        chk("reset_outs", outs(), 0);
        rst = 1'b0;
        tick;
        chk("idle_outs", outs(), 0);

        for (int i = 0; i < 5; i++) run_seq(vecs[i].op, vecs[i].len, vecs[i].err);

        // Tie from reset: seq first, then xfer, then seq again.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        seq_req = 1'b1;
        seq_op = 2'd0;
        xfer_req = 1'b1;
        tick;
        chk("tie1_seq_ack", seq_ack, 1);
        chk("tie1_no_gnt", xfer_gnt, 0);
        wait_seq_done("tie1_done");
        chk("tie_gap_gnt", xfer_gnt, 0);
        tick;
        chk("tie2_gnt", xfer_gnt, 1);
        chk("tie2_no_hold", {fe_hold, swdio_oe, swclk_en}, 0);
        xfer_done = 1'b1;
        tick;
        xfer_done = 1'b0;
        chk("tie2_gnt_drop", xfer_gnt, 0);
        chk("tie2_no_timeout", xfer_timeout, 0);
        tick;
        chk("tie3_seq_ack", seq_ack, 1);
        chk("tie3_no_gnt", xfer_gnt, 0);
        seq_req = 1'b0;
        xfer_req = 1'b0;
        wait_seq_done("tie3_done");

        // Watchdog expiry with no xfer_done.
        begin
            int n;
            int tos;
            xfer_req = 1'b1;
            tick;
            xfer_req = 1'b0;
            n = 0;
            tos = 0;
            while (xfer_gnt && n < 50) begin
                if (xfer_timeout) tos++;
                n++;
                tick;
            end
            chk("wd_gnt_cycles", n, 8);
            chk("wd_early_pulse", tos, 0);
            chk("wd_pulse", xfer_timeout, 1);
            chk("wd_busy", busy, 0);
            tick;
            chk("wd_pulse_once", xfer_timeout, 0);
        end

        // xfer_done on the final watchdog cycle is a normal completion.
        xfer_req = 1'b1;
        tick;
        xfer_req = 1'b0;
        repeat (7) tick;
        chk("wdp_still_gnt", xfer_gnt, 1);
        xfer_done = 1'b1;
        tick;
        xfer_done = 1'b0;
        chk("wdp_gnt_drop", xfer_gnt, 0);
        chk("wdp_no_timeout", xfer_timeout, 0);

        // xfer_done while not granted is ignored.
        xfer_done = 1'b1;
        tick;
        xfer_done = 1'b0;
        chk("stray_done", outs(), 0);

        // Reset in the middle of the switch code.
        seq_req = 1'b1;
        seq_op = 2'd2;
        tick;
        seq_req = 1'b0;
        seq_op = 2'd0;
        repeat (70) tick;
        chk("mid_sw16_oe", swdio_oe, 1);
        rst = 1'b1;
        tick;
        chk("abort_outs", outs(), 0);
        rst = 1'b0;
        tick;
        chk("abort_no_done", outs(), 0);
        run_seq(2'd1, 50, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
